// File: rtl/snitch_perf_counter_bank_if.sv
// rtl/snitch_perf_counter_bank_if.sv - register request/response bundle for the perf counter bank
// Purpose: groups the single-cycle register request and its response into one port.
// Signals:
//   req_valid_i  request strobe, one access per cycle, never back-pressured
//   req_write_i  1 = write, 0 = read
//   req_addr_i   [7:2] counter index, [1:0] register select
//   req_wdata_i  write data
//   rsp_valid_o  response strobe, one cycle after the request
//   rsp_rdata_o  read data (0 for writes and invalid accesses)
//   rsp_error_o  request addressed a counter that does not exist
interface snitch_perf_counter_bank_if;
    logic        req_valid_i;
    logic        req_write_i;
    logic [7:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  rsp_valid_o, rsp_rdata_o, rsp_error_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output rsp_valid_o, rsp_rdata_o, rsp_error_o
    );
endinterface

// File: rtl/snitch_perf_counter_bank.sv
// rtl/snitch_perf_counter_bank.sv - bank of configurable per-core event counters
// Purpose: each counter sums one selected event bit over a hart mask, in wrap or
// saturate mode, with sticky overflow, level interrupt and LO/HI shadowed readout.
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset
//   events_i  per-core event strobes, core c at [c*NumEvents +: NumEvents]
//   bus       register request/response (slave side)
//   irq_o     OR of (overflow & irq_en) over all counters
module snitch_perf_counter_bank #(
    parameter int unsigned NumCores     = 8,
    parameter int unsigned NumEvents    = 7,
    parameter int unsigned NumCounters  = 4,
    parameter int unsigned CounterWidth = 48
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumCores*NumEvents-1:0] events_i,
    snitch_perf_counter_bank_if.slave     bus,
    output logic                          irq_o
);
    localparam int unsigned IncW = $clog2(NumCores + 1);
    localparam int unsigned HiW  = CounterWidth - 32;
    // Writable CFG bits: en, sat, event idx, irq_en and the hart mask.
    localparam logic [31:0] CfgMask = (((32'd1 << NumCores) - 32'd1) << 16) | 32'h0000_009F;

    logic [NumCores-1:0][NumEvents-1:0] events_q, events_d;
    logic [31:0]             cfg_q    [NumCounters];
    logic [31:0]             cfg_d    [NumCounters];
    logic [CounterWidth-1:0] cnt_q    [NumCounters];
    logic [CounterWidth-1:0] cnt_d    [NumCounters];
    logic [HiW-1:0]          shadow_q [NumCounters];
    logic [HiW-1:0]          shadow_d [NumCounters];
    logic [NumCounters-1:0]  ovf_q, ovf_d;
    logic                    irq_q, irq_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_error_q, rsp_error_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;

    logic [IncW-1:0]         inc     [NumCounters];
    logic [CounterWidth:0]   sum     [NumCounters];
    logic [NumCounters-1:0]  ovf_set;
    logic [5:0]              req_idx;
    logic [1:0]              req_sel;
    logic                    req_in_range;

    // Increment datapath, driven purely by the registered strobes.
    always_comb begin
        for (int k = 0; k < NumCounters; k++) begin
            inc[k] = '0;
            for (int c = 0; c < NumCores; c++) begin
                if (cfg_q[k][16+c] && (int'(cfg_q[k][4:2]) < NumEvents)) begin
                    inc[k] = inc[k] + IncW'(events_q[c][cfg_q[k][4:2]]);
                end
            end
            sum[k] = {1'b0, cnt_q[k]} + (CounterWidth+1)'(inc[k]);
        end
    end

    always_comb begin
        events_d     = events_i;
        req_idx      = bus.req_addr_i[7:2];
        req_sel      = bus.req_addr_i[1:0];
        req_in_range = int'(req_idx) < NumCounters;
        rsp_valid_d  = bus.req_valid_i;
        rsp_error_d  = bus.req_valid_i && !req_in_range;
        rsp_rdata_d  = '0;
        irq_d        = 1'b0;
        ovf_set      = '0;

        for (int k = 0; k < NumCounters; k++) begin
            cfg_d[k]    = cfg_q[k];
            cnt_d[k]    = cnt_q[k];
            shadow_d[k] = shadow_q[k];
            ovf_d[k]    = ovf_q[k];
            irq_d       = irq_d | (ovf_q[k] & cfg_q[k][7]);

            if (cfg_q[k][0] && (inc[k] != '0)) begin
                ovf_set[k] = sum[k][CounterWidth];
                if (sum[k][CounterWidth] && cfg_q[k][1]) begin
                    cnt_d[k] = '1;
                end else begin
                    cnt_d[k] = sum[k][CounterWidth-1:0];
                end
            end
            ovf_d[k] = ovf_q[k] | ovf_set[k];

            if (bus.req_valid_i && (req_idx == 6'(k))) begin
                if (bus.req_write_i) begin
                    unique case (req_sel)
                        2'd0: cfg_d[k] = bus.req_wdata_i & CfgMask;
                        // Counter writes override a same-cycle increment, including its overflow.
                        2'd1: begin
                            cnt_d[k] = {cnt_q[k][CounterWidth-1:32], bus.req_wdata_i};
                            ovf_d[k] = ovf_q[k];
                        end
                        2'd2: begin
                            cnt_d[k] = {bus.req_wdata_i[HiW-1:0], cnt_q[k][31:0]};
                            ovf_d[k] = ovf_q[k];
                        end
                        // A new overflow in the same cycle beats the clear.
                        default: ovf_d[k] = (ovf_q[k] & ~bus.req_wdata_i[0]) | ovf_set[k];
                    endcase
                end else begin
                    unique case (req_sel)
                        2'd0: rsp_rdata_d = cfg_q[k];
                        2'd1: begin
                            rsp_rdata_d = cnt_q[k][31:0];
                            shadow_d[k] = cnt_q[k][CounterWidth-1:32];
                        end
                        2'd2:    rsp_rdata_d = 32'(shadow_q[k]);
                        default: rsp_rdata_d = {31'b0, ovf_q[k]};
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            events_q    <= '0;
            ovf_q       <= '0;
            irq_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            for (int k = 0; k < NumCounters; k++) begin
                cfg_q[k]    <= '0;
                cnt_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
        end else begin
            events_q    <= events_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            for (int k = 0; k < NumCounters; k++) begin
                cfg_q[k]    <= cfg_d[k];
                cnt_q[k]    <= cnt_d[k];
                shadow_q[k] <= shadow_d[k];
            end
        end
    end

    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_error_o = rsp_error_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign irq_o           = irq_q;
endmodule

// File: tb/tb_snitch_perf_counter_bank.sv
// tb/tb_snitch_perf_counter_bank.sv - self-checking bench for snitch_perf_counter_bank
module tb_snitch_perf_counter_bank;
    localparam int NC = 8;
    localparam int NE = 7;
    localparam int NK = 4;
    localparam int CW = 48;
    localparam longint unsigned MAXV    = (64'd1 << CW) - 1;
    localparam logic [31:0]     CFGMASK = (((32'd1 << NC) - 32'd1) << 16) | 32'h0000_009F;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*NE-1:0]  events;
    logic              irq;

    snitch_perf_counter_bank_if bus ();

    snitch_perf_counter_bank #(
        .NumCores(NC), .NumEvents(NE), .NumCounters(NK), .CounterWidth(CW)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .events_i(events),
        .bus     (bus),
        .irq_o   (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    longint unsigned m_cnt    [NK];
    longint unsigned m_shadow [NK];
    logic [31:0]     m_cfg    [NK];
    bit              m_ovf    [NK];
    logic [NC*NE-1:0] m_ev;
    bit              m_irq;
    bit              e_valid, e_err;
    logic [31:0]     e_data;
    logic [NC*NE-1:0] ev_drive;
    logic [31:0]     last_rdata;
    logic            last_err;
    logic [NC*NE-1:0] all_retired;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NK; k++) begin
            m_cnt[k] = 0; m_shadow[k] = 0; m_cfg[k] = 0; m_ovf[k] = 0;
        end
        m_ev = '0; m_irq = 0;
    endtask

    // One clock of the bank as seen from the register map: counts in plain integers.
    task automatic model_step(input bit v, input bit w, input logic [7:0] a, input logic [31:0] d);
        int kr, sel, idx, inc;
        bit set, nirq;
        longint unsigned s;
        longint unsigned ncnt [NK];
        bit nov [NK];
        kr = int'(a[7:2]); sel = int'(a[1:0]);
        e_valid = v; e_err = v && (kr >= NK); e_data = 0;
        if (v && !w && kr < NK) begin
            case (sel)
                0: e_data = m_cfg[kr];
                1: e_data = 32'(m_cnt[kr]);
                2: e_data = 32'(m_shadow[kr]);
                default: e_data = {31'b0, m_ovf[kr]};
            endcase
        end
        nirq = 0;
        for (int k = 0; k < NK; k++) nirq |= m_ovf[k] && m_cfg[k][7];
        for (int k = 0; k < NK; k++) begin
            idx = int'(m_cfg[k][4:2]); inc = 0; set = 0;
            if (idx < NE)
                for (int c = 0; c < NC; c++)
                    if (m_cfg[k][16+c]) inc += int'(m_ev[c*NE+idx]);
            s = m_cnt[k] + longint'(inc);
            if (m_cfg[k][0] && s > MAXV) begin
                set = 1;
                s = m_cfg[k][1] ? MAXV : s - (MAXV + 1);
            end
            ncnt[k] = m_cfg[k][0] ? s : m_cnt[k];
            nov[k]  = m_ovf[k] | set;
            if (v && k == kr) begin
                if (w) begin
                    case (sel)
                        0: m_cfg[k] = d & CFGMASK;
                        1: begin ncnt[k] = (m_cnt[k] & ~64'hFFFF_FFFF) | longint'(d); nov[k] = m_ovf[k]; end
                        2: begin
                            ncnt[k] = ((longint'(d) & ((64'd1 << (CW-32)) - 1)) << 32) | (m_cnt[k] & 64'hFFFF_FFFF);
                            nov[k] = m_ovf[k];
                        end
                        default: nov[k] = (m_ovf[k] & !d[0]) | set;
                    endcase
                end else if (sel == 1) begin
                    m_shadow[k] = m_cnt[k] >> 32;
                end
            end
        end
        for (int k = 0; k < NK; k++) begin m_cnt[k] = ncnt[k]; m_ovf[k] = nov[k]; end
        m_irq = nirq;
        m_ev  = ev_drive;
    endtask

    task automatic step(input bit v, input bit w, input logic [7:0] a, input logic [31:0] d);
        bus.req_valid_i = v; bus.req_write_i = w; bus.req_addr_i = a; bus.req_wdata_i = d;
        events = ev_drive;
        model_step(v, w, a, d);
        @(posedge clk); #1;
        check("rsp_valid", 64'(bus.rsp_valid_o), 64'(e_valid));
        check("rsp_error", 64'(bus.rsp_error_o), 64'(e_err));
        check("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(e_data));
        check("irq", 64'(irq), 64'(m_irq));
        last_rdata = bus.rsp_rdata_o;
        last_err   = bus.rsp_error_o;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 32'h0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(1, 1, a, d);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        step(1, 0, a, 32'h0);
        check(tag, 64'(last_rdata), 64'(exp));
    endtask

    initial begin
        all_retired = '0;
        for (int c = 0; c < NC; c++) all_retired[c*NE+3] = 1'b1;
        rst = 1'b1; ev_drive = '0; events = '0;
        bus.req_valid_i = 0; bus.req_write_i = 0; bus.req_addr_i = 0; bus.req_wdata_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("reset_rsp_rdata", 64'(bus.rsp_rdata_o), 64'd0);
        check("reset_rsp_error", 64'(bus.rsp_error_o), 64'd0);
        check("reset_irq", 64'(irq), 64'd0);
        rst = 1'b0;

        rd(8'h00, 32'h0, "reset_cfg0");
        rd(8'h01, 32'h0, "reset_lo0");
        rd(8'h03, 32'h0, "reset_status0");
        check("reset_err", 64'(last_err), 64'd0);

        // Counter 1: retired_instr on all cores, full mask then mask 0x05.
        wr(8'h04, 32'h00FF_000D);
        rd(8'h04, 32'h00FF_000D, "cfg1_readback");
        ev_drive = all_retired;
        idle(10);
        ev_drive = '0;
        idle(2);
        rd(8'h05, 32'd80, "count_all_harts");
        wr(8'h05, 32'h0);
        wr(8'h04, 32'h0005_000D);
        ev_drive = all_retired;
        idle(10);
        ev_drive = '0;
        idle(2);
        rd(8'h05, 32'd20, "count_mask_05");

        // Counter 0 wrap with interrupt.
        wr(8'h00, 32'h0001_008D);
        wr(8'h02, 32'h0000_FFFF);
        wr(8'h01, 32'hFFFF_FFFE);
        ev_drive = 56'd8;
        idle(3);
        ev_drive = '0;
        idle(3);
        rd(8'h01, 32'd1, "wrap_lo");
        rd(8'h02, 32'd0, "wrap_hi");
        rd(8'h03, 32'd1, "wrap_ovf");
        check("wrap_irq", 64'(irq), 64'd1);
        wr(8'h03, 32'd1);
        idle(2);
        check("w1c_irq", 64'(irq), 64'd0);

        // Counter 0 saturate.
        wr(8'h00, 32'h0001_008F);
        wr(8'h02, 32'h0000_FFFF);
        wr(8'h01, 32'hFFFF_FFFE);
        ev_drive = 56'd8;
        idle(3);
        ev_drive = '0;
        idle(3);
        rd(8'h01, 32'hFFFF_FFFF, "sat_lo");
        rd(8'h02, 32'h0000_FFFF, "sat_hi");
        rd(8'h03, 32'd1, "sat_ovf");
        ev_drive = 56'd8;
        idle(2);
        ev_drive = '0;
        idle(3);
        rd(8'h01, 32'hFFFF_FFFF, "sat_hold");

        // Reset in the middle of counting clears everything immediately.
        ev_drive = all_retired;
        idle(2);
        #3 rst = 1'b1;
        #1;
        check("midreset_irq", 64'(irq), 64'd0);
        check("midreset_valid", 64'(bus.rsp_valid_o), 64'd0);
        ev_drive = '0; events = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        rd(8'h05, 32'd0, "midreset_cnt1");
        rd(8'h03, 32'd0, "midreset_ovf0");

        // Atomic LO/HI pair on counter 2 while it crosses 2^32.
        wr(8'h09, 32'hFFFF_FFFF);
        wr(8'h0A, 32'h0);
        ev_drive = all_retired;
        idle(1);
        wr(8'h08, 32'h00FF_000D);
        rd(8'h09, 32'hFFFF_FFFF, "atomic_lo");
        rd(8'h0A, 32'h0, "atomic_hi");

        // Write beats a same-cycle increment.
        ev_drive = '0;
        wr(8'h09, 32'd5);
        rd(8'h09, 32'd5, "write_wins");

        // Nonexistent counter.
        rd(8'h1D, 32'h0, "invalid_rdata");
        check("invalid_rd_err", 64'(last_err), 64'd1);
        wr(8'h1C, 32'hFFFF_FFFF);
        check("invalid_wr_err", 64'(last_err), 64'd1);

        // Event index beyond NumEvents never counts.
        wr(8'h0C, 32'h00FF_001D);
        ev_drive = '1;
        idle(4);
        ev_drive = '0;
        idle(2);
        rd(8'h0D, 32'd0, "idx_out_of_range");

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [7:0]  a;
            logic [31:0] d;
            bit v, w;
            ev_drive = (NC*NE)'({$urandom(), $urandom()});
            v = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            a = 8'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3));
            d = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63))) : $urandom();
            step(v, w, a, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/snitch_perf_counter_bank.md
Name: snitch_perf_counter_bank

Overview:
- Parametrised bank of event counters for the cluster peripherals.
- Counts per-core event strobes (core_events_t layout, 7 bits per core) across a configurable hart subset.
- Successor to the fixed per-core strobe set: adds selectable event/hart mask per counter, wide counters, wrap/saturate modes, sticky overflow with interrupt, and atomic 64-bit readout over a 32-bit register port.

Parameters:
- NumCores, 8, number of cores feeding events (1..16).
- NumEvents, 7, event bits per core (core_events_t width).
- NumCounters, 4, number of independent counters (1..16).
- CounterWidth, 48, counter width in bits (33..64).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- events_i  in  NumCores*NumEvents  event strobes; core c occupies bits [c*NumEvents +: NumEvents].
- req_valid_i  in  1  register access request.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  8  word address: [7:2] counter index, [1:0] register select.
- req_wdata_i  in  32  write data.
- rsp_valid_o  out  1  response valid, exactly 1 cycle after each request.
- rsp_rdata_o  out  32  read data (0 for writes).
- rsp_error_o  out  1  access to a nonexistent counter.
- irq_o  out  1  overflow interrupt, level.

Behaviour:
- Reset: all counters, CFG, STATUS and the HI shadow are 0; rsp_valid_o=0, rsp_rdata_o=0, rsp_error_o=0, irq_o=0. Reset mid-count clears everything immediately; there is no pending state.
- Register select:
  - 0 CFG: [0] en, [1] sat, [4:2] event idx, [7] irq_en, [16+NumCores-1:16] hart mask; other bits read 0.
  - 1 VAL_LO.
  - 2 VAL_HI.
  - 3 STATUS: [0] ovf, sticky, write-1-to-clear.
- Event pipeline: events_i is registered once. The increment is computed from the registered strobes and applied at the next edge. An event high in cycle t is visible to a read issued in cycle t+2.
- Increment: inc = popcount over cores c with mask[c]=1 of event[c][idx]. inc has $clog2(NumCores+1) bits and is zero-extended to CounterWidth.
  - event idx >= NumEvents gives inc=0.
  - en=0 gives no update.
- Wrap mode (sat=0): counter <= (counter+inc) mod 2^CounterWidth; ovf set on carry out.
- Saturate mode (sat=1): counter <= min(counter+inc, 2^CounterWidth-1); ovf set when clamping.
- irq_o = OR over counters of (ovf & irq_en), registered from state. Asserts the cycle after ovf sets.
- Reads:
  - VAL_LO returns counter[31:0] and latches counter[CounterWidth-1:32] into that counter's HI shadow in the same cycle.
  - VAL_HI returns the shadow zero-extended, giving a consistent 64-bit value for the pair LO then HI.
- Writes:
  - VAL_LO/VAL_HI write the corresponding slice. HI bits above CounterWidth are ignored.
  - A write to a counter in the same cycle as a nonzero increment: the write wins and the increment is dropped.
  - A STATUS W1C in the same cycle as a new overflow: the set wins.
- Invalid access (counter index >= NumCounters): write ignored, read data 0, rsp_error_o=1 with the response.
- Handshake: requests are always accepted, one per cycle, no backpressure. rsp_valid_o pulses 1 cycle per request; back-to-back requests give back-to-back responses.

Test Plan:
- Reset then read CFG/VAL_LO/STATUS of counter 0: all return 0, rsp_error_o=0, irq_o=0.
- Counter 1: CFG en=1, idx=3 (retired_instr), mask=0x00FF. Drive retired_instr on all 8 cores for 10 cycles, then read VAL_LO: returns 80. With mask=0x0005 the same stimulus gives 20.
- Counter 0, wrap mode: write VAL_HI=0xFFFF, VAL_LO=0xFFFFFFFE (48-bit), irq_en=1, then 3 single-core events. Counter ends at 1, STATUS=1, irq_o=1. W1C STATUS gives irq_o=0 next cycle.
- Same setup with sat=1: counter holds 0xFFFF_FFFFFFFF and ovf=1; further events keep the value unchanged.
- Atomic read: counter at 0x0000_FFFFFFFF with continuous 8/cycle events. Read LO (0xFFFFFFFF + pipeline delta), then HI: HI returns 0 (shadow), not 1.
- Same-cycle write and increment: write VAL_LO=5 while inc=8. Next read returns 5. Access to counter index 7 with NumCounters=4: rsp_error_o=1, rdata=0.
